// File: rtl/vga_text_console_pkg.sv
// rtl/vga_text_console_pkg.sv - geometry, blank value, control codes and console state enum
package vga_text_console_pkg;

  localparam int VGA_ADDR_W = 12;
  localparam int INFO_W     = 8;

  localparam logic [11:0] TXT_COLS    = 12'd100;
  localparam logic [11:0] TXT_CELLS   = 12'd3700;
  localparam logic [11:0] LAST_CELL   = 12'd3699;
  localparam logic [11:0] SCROLL_LAST = 12'd3599;
  localparam logic [5:0]  LAST_ROW    = 6'd36;
  localparam logic [6:0]  LAST_COL    = 7'd99;

  localparam logic [7:0] BLANK_CH  = 8'h20;
  localparam logic [7:0] BLANK_CLR = 8'h00;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_SCROLL_BLANK
  } console_state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_ram.sv
// rtl/text_ram.sv - 4096x16 dual-port cell RAM: port A read-only (VGA), port B read/write (console)
module text_ram #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic [AW-1:0] a_addr_i,
  output logic [DW-1:0] a_rdata_o,
  input  logic          b_we_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] b_wdata_i,
  output logic [DW-1:0] b_rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Registered reads see the pre-write contents on an address collision.
  always_ff @(posedge clk) begin
    a_rdata_o <= mem_q[a_addr_i];
    b_rdata_o <= mem_q[b_addr_i];
    if (b_we_i) begin
      mem_q[b_addr_i] <= b_wdata_i;
    end
  end

endmodule

// File: rtl/vga_text_console.sv
// rtl/vga_text_console.sv - console writer with cursor, control codes, clear and scroll over a text RAM
module vga_text_console
  import vga_text_console_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INFO_W-1:0]     in_char,
  input  logic [INFO_W-1:0]     in_color,
  input  logic [VGA_ADDR_W-1:0] vga_addr,
  output logic [INFO_W-1:0]     ch,
  output logic [INFO_W-1:0]     color,
  output logic                  busy,
  output logic [5:0]            cursor_row,
  output logic [6:0]            cursor_col
);

  console_state_e state_q, state_d;
  logic [11:0] ptr_q, ptr_d;
  logic [5:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic        vga_blank_q;

  logic        b_we;
  logic [11:0] b_addr;
  logic [15:0] b_wdata;
  logic [15:0] b_rdata;
  logic [15:0] a_rdata;
  logic [11:0] cell_addr;
  logic        newline;

  text_ram u_ram (
    .clk       (clk),
    .a_addr_i  (vga_addr),
    .a_rdata_o (a_rdata),
    .b_we_i    (b_we),
    .b_addr_i  (b_addr),
    .b_wdata_i (b_wdata),
    .b_rdata_o (b_rdata)
  );

  assign cell_addr = 12'(row_q) * TXT_COLS + 12'(col_q);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    row_d    = row_q;
    col_d    = col_q;
    b_we     = 1'b0;
    b_addr   = ptr_q;
    b_wdata  = {BLANK_CH, BLANK_CLR};
    in_ready = 1'b0;
    busy     = 1'b1;
    newline  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        b_we  = 1'b1;
        ptr_d = ptr_q + 12'd1;
        if (ptr_q == LAST_CELL) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        b_addr   = cell_addr;
        if (in_valid) begin
          case (in_char)
            CC_LF: begin
              col_d   = 7'd0;
              newline = 1'b1;
            end
            CC_CR: col_d = 7'd0;
            CC_BS: begin
              if (col_q != 7'd0) begin
                col_d  = col_q - 7'd1;
                b_we   = 1'b1;
                b_addr = cell_addr - 12'd1;
              end
            end
            CC_FF: begin
              row_d   = 6'd0;
              col_d   = 7'd0;
              ptr_d   = 12'd0;
              state_d = ST_CLEAR;
            end
            default: begin
              if (is_printable(in_char)) begin
                b_we    = 1'b1;
                b_wdata = {in_char, in_color};
                if (col_q == LAST_COL) begin
                  col_d   = 7'd0;
                  newline = 1'b1;
                end else begin
                  col_d = col_q + 7'd1;
                end
              end
            end
          endcase
          if (newline) begin
            if (row_q < LAST_ROW) begin
              row_d = row_q + 6'd1;
            end else begin
              ptr_d   = 12'd0;
              state_d = ST_SCROLL_RD;
            end
          end
        end
      end
      ST_SCROLL_RD: begin
        b_addr  = ptr_q + TXT_COLS;
        state_d = ST_SCROLL_WR;
      end
      ST_SCROLL_WR: begin
        // b_rdata holds cell ptr+100 fetched in the previous cycle
        b_we    = 1'b1;
        b_wdata = b_rdata;
        ptr_d   = ptr_q + 12'd1;
        state_d = (ptr_q == SCROLL_LAST) ? ST_SCROLL_BLANK : ST_SCROLL_RD;
      end
      ST_SCROLL_BLANK: begin
        b_we  = 1'b1;
        ptr_d = ptr_q + 12'd1;
        if (ptr_q == LAST_CELL) state_d = ST_IDLE;
      end
      default: begin
        ptr_d   = 12'd0;
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= 12'd0;
      row_q       <= 6'd0;
      col_q       <= 7'd0;
      vga_blank_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      vga_blank_q <= (vga_addr >= TXT_CELLS);
    end
  end

  assign ch         = vga_blank_q ? BLANK_CH  : a_rdata[15:8];
  assign color      = vga_blank_q ? BLANK_CLR : a_rdata[7:0];
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_vga_text_console.sv
// tb/tb_vga_text_console.sv - directed self-checking bench for vga_text_console
module tb_vga_text_console;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic [7:0]  in_color;
  logic [11:0] vga_addr;
  logic [7:0]  ch;
  logic [7:0]  color;
  logic        busy;
  logic [5:0]  cursor_row;
  logic [6:0]  cursor_col;

  int checks = 0;
  int errors = 0;

  vga_text_console dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_color   (in_color),
    .vga_addr   (vga_addr),
    .ch         (ch),
    .color      (color),
    .busy       (busy),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] clr);
    int n;
    n = 0;
    in_char  = c;
    in_color = clr;
    in_valid = 1'b1;
    while (!in_ready && n < 20000) begin
      tick();
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp);
    int n;
    n = 0;
    while (!in_ready && n < 20000) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      checks--;
      tick();
      n++;
    end
    check(tag, n, exp);
  endtask

  task automatic vga_rd(input int a, output logic [15:0] d);
    vga_addr = 12'(a);
    tick();
    d = {ch, color};
  endtask

  task automatic sweep(input string tag);
    int bad;
    logic [15:0] d;
    bad = 0;
    for (int i = 0; i < 3700; i++) begin
      vga_rd(i, d);
      if (d !== 16'h2000) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic check_cursor(input string tag, input int r, input int c);
    check({tag, "_row"}, 32'(cursor_row), r);
    check({tag, "_col"}, 32'(cursor_col), c);
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] exp;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_char  = 8'h00;
    in_color = 8'h00;
    vga_addr = 12'd0;
    repeat (3) tick();

    check("rst_ch", 32'(ch), 32'h20);
    check("rst_color", 32'(color), 32'h0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check_cursor("rst_cursor", 0, 0);

    rst = 1'b0;
    wait_ready("clear_cycles", 3700);
    check("idle_busy", 32'(busy), 32'd0);
    sweep("clear_sweep");
    vga_rd(4000, d);
    check("oob_4000", d, 16'h2000);

    send(8'h41, 8'd2);
    send(8'h42, 8'd5);
    check_cursor("ab_cursor", 0, 2);
    vga_rd(1, d);
    check("cell1", d, 16'h4205);
    vga_addr = 12'd0;
    #1;
    check("latency_old", {24'd0, ch}, 32'h42);
    tick();
    check("cell0", {ch, color}, 16'h4102);

    for (int i = 0; i < 5; i++) send(8'h0A, 8'd0);
    for (int i = 0; i < 99; i++) send(8'h2E, 8'd0);
    check_cursor("pre_z", 5, 99);
    send(8'h5A, 8'd1);
    check_cursor("wrap_z", 6, 0);
    vga_rd(599, d);
    check("cell599", d, 16'h5A01);
    send(8'h0A, 8'd0);
    check_cursor("lf_after_wrap", 7, 0);

    send(8'h0C, 8'd0);
    check_cursor("ff1_cursor", 0, 0);
    wait_ready("ff1_cycles", 3700);
    vga_rd(599, d);
    check("ff1_cell599", d, 16'h2000);

    for (int i = 0; i < 3; i++) send(8'h0A, 8'd0);
    send(8'h08, 8'd0);
    check_cursor("bs_col0", 3, 0);
    send(8'h77, 8'd3);
    send(8'h78, 8'd3);
    send(8'h79, 8'd3);
    send(8'h7A, 8'd3);
    check_cursor("pre_bs", 3, 4);
    send(8'h08, 8'd0);
    check_cursor("bs_col4", 3, 3);
    vga_rd(303, d);
    check("bs_cell303", d, 16'h2000);
    vga_rd(302, d);
    check("bs_cell302", d, 16'h7903);
    send(8'h07, 8'd0);
    check_cursor("ignored_code", 3, 3);
    send(8'h0D, 8'd0);
    check_cursor("cr", 3, 0);

    send(8'h0C, 8'd0);
    wait_ready("ff2_cycles", 3700);
    check_cursor("ff2_cursor", 0, 0);
    vga_rd(302, d);
    check("ff2_cell302", d, 16'h2000);

    for (int r = 0; r < 37; r++) begin
      send(8'(8'h30 + r), 8'(r % 7));
      send(8'h0A, 8'd0);
    end
    wait_ready("scroll_cycles", 7300);
    check_cursor("scroll_cursor", 36, 0);
    for (int r = 0; r < 36; r++) begin
      exp = {8'(8'h31 + r), 8'((r + 1) % 7)};
      vga_rd(r * 100, d);
      check("scroll_row", d, exp);
    end
    vga_rd(3600, d);
    check("scroll_row36", d, 16'h2000);
    vga_rd(3699, d);
    check("scroll_last", d, 16'h2000);

    send(8'h0A, 8'd0);
    repeat (2000) tick();
    check("mid_scroll_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cursor("rst_mid_cursor", 0, 0);
    check("rst_mid_ready", 32'(in_ready), 32'd0);
    wait_ready("rst_mid_clear", 3700);
    sweep("rst_mid_sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_text_console.md
# vga_text_console

Character-cell text buffer and console writer feeding the VGA scan-out engine. Accepts a stream of (character, color) bytes from the CPU-side MMIO path over a valid/ready handshake. Maintains a cursor, interprets control codes, clears and scrolls the screen. Answers the VGA engine's `vga_addr` lookups with `ch`/`color` for every cell of the 100×37 grid.

## Interface
Parameters:
- None. Geometry comes from `Const.svh`.

Ports:
- `clk`  in  1  the single clock (40 MHz VGA clock); every port is synchronous to it
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  a console byte is offered
- `in_ready`  out  1  console can accept a byte this cycle
- `in_char`  in  `INFO_WID` (8)  character or control code
- `in_color`  in  `INFO_WID` (8)  color index: 0 white, 1 yellow, 2 red, 3 pink, 4 orange, 5 light blue, 6 dark blue
- `vga_addr`  in  `VGA_ADDR` (12)  cell index requested by the VGA engine, row*100+col
- `ch`  out  `INFO_WID`  character at the requested cell
- `color`  out  `INFO_WID`  color at the requested cell
- `busy`  out  1  clear or scroll is in progress
- `cursor_row`  out  6  current cursor row, 0..36
- `cursor_col`  out  7  current cursor column, 0..99

## Operation
- Grid geometry: 100 columns × 37 rows = 3700 cells. Each cell holds {char[7:0], color[7:0]}.
- Blank cell value: char 0x20, color 0.
- State machine states: CLEAR, IDLE, SCROLL_RD, SCROLL_WR, SCROLL_BLANK.
- Reset:
  - Enters CLEAR with the clear pointer at 0 and the cursor at (0,0).
  - `ch`=0x20, `color`=0, `in_ready`=0, `busy`=1.
- CLEAR: writes a blank to one cell per cycle, cells 0..3699, then goes to IDLE.
- IDLE:
  - `in_ready`=1 and `busy`=0.
  - A byte is consumed on `in_valid && in_ready`.
- Byte handling in IDLE:
  - 0x20..0x7E: write {in_char, in_color} at cell row*100+col, then advance col.
  - Advancing from col 99: col becomes 0 and a newline is performed.
  - 0x0A (LF): col becomes 0 and a newline is performed.
  - 0x0D (CR): col becomes 0.
  - 0x08 (BS): if col>0, col decrements and a blank is written at the new col. At col 0 the byte is a no-op; the cursor never moves back a row.
  - 0x0C (FF): cursor goes to (0,0) and the state goes to CLEAR.
  - All other codes are accepted and ignored.
- Newline:
  - If row<36: row increments.
  - If row==36: row stays 36 and the state goes to SCROLL_RD with scroll pointer i=0.
- Scroll:
  - SCROLL_RD reads cell i+100.
  - SCROLL_WR writes that data to cell i, increments i, and returns to SCROLL_RD while i<3600.
  - SCROLL_BLANK then writes blanks to cells 3600..3699, one per cycle, then goes to IDLE.
- VGA read port:
  - Independent of console activity and never stalls.
  - `vga_addr` ≥ 3700 returns 0x20/0.
  - Same-cycle write and read of the same cell returns the old data (read-first).
- Reset mid-clear or mid-scroll abandons the operation and restarts CLEAR from cell 0.

## Timing
- VGA read latency: exactly 1 cycle. `ch`/`color` in cycle t+1 reflect the `vga_addr` sampled in cycle t.
- Accepted printable byte: the cell write commits at the end of the acceptance cycle. A VGA read of that cell is visible from the next cycle.
- Throughput in IDLE: 1 byte per cycle, with no bubble between consecutive bytes unless a scroll or clear starts.
- The cursor updates in the cycle after acceptance, and `cursor_row`/`cursor_col` are registered.
- CLEAR: 3700 cycles. `in_ready` rises in the cycle after the write to cell 3699.
- Scroll: 7200 cycles (2 per copied cell) plus 100 cycles blanking, 7300 total. `in_ready` rises the cycle after the write to cell 3699.
- `busy` = !`in_ready`, except that `busy` is 0 while in IDLE.

## Structure
- `Const.svh` gains:
  - `TXT_COLS`=100, `TXT_ROWS`=37, `TXT_CELLS`=3700
  - `VGA_ADDR`=11:0, `INFO_WID`=7:0
  - `BLANK_CH`=8'h20
  - the console state enum
  - the control-code constants
- Sub-module `text_ram`:
  - 4096×16 true dual-port block RAM.
  - Port A: registered read-only for VGA, with the out-of-range substitution done in `vga_text_console`.
  - Port B: read/write for the console FSM.
- Cursor, pointers and FSM stay in `vga_text_console`.

## Test plan
- Reset then 3700 idle cycles:
  - `in_ready` rises at cycle 3700.
  - A VGA sweep of 0..3699 returns 0x20/0 everywhere.
  - `vga_addr`=4000 returns 0x20/0.
- Send 'A' color 2, then 'B' color 5:
  - cell 0 = 0x41/2 and cell 1 = 0x42/5.
  - Cursor is (0,2).
  - Cell 0 reads back 1 cycle after its address is applied.
- At cursor (5,99) send 'Z', then LF:
  - cell 599 = 'Z' and the cursor goes to (6,0).
  - The LF moves the cursor to (7,0).
- Fill rows with a row-index char, then LF at row 36:
  - `busy` is held for 7300 cycles.
  - Afterwards row r holds the old row r+1, row 36 is blank, and the cursor is (36,0).
- BS cases:
  - BS at (3,0): no change.
  - BS at (3,4): cell 303 is blank and the cursor is (3,3).
  - FF: full clear, cursor (0,0).
- Assert `rst` mid-scroll (cycle 2000): CLEAR restarts, the cursor is (0,0), and all cells are blank after 3700 cycles.
